// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master round-robin Wishbone arbiter with stall watchdog
//
// Purpose:
//   Shares one Wishbone slave port between the data-side master (m0) and the
//   instruction-side master (m1). Ownership is granted from IDLE, held for the
//   whole bus cycle (while cyc stays high), and always returns through IDLE, so
//   there is one dead cycle between owners. A watchdog forces an error to the
//   owner when its strobe waits TIMEOUT cycles without an ack.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mN_addr_i/data_i/we_i/
//   sel_i/stb_i/cyc_i         master N request (N = 0 data side, 1 instruction side)
//   mN_data_o/ack_o/err_o     master N response (zero unless N owns the bus)
//   s_addr_o/data_o/we_o/
//   sel_o/stb_o/cyc_o         slave request, muxed from the owner (zero in IDLE)
//   s_data_i/ack_i            slave response
//   grant_o                   one-hot owner: 01 = m0, 10 = m1, 00 = idle
module wb_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_data_i,
   output logic [DW-1:0] m0_data_o,
   input  logic          m0_we_i,
   input  logic [3:0]    m0_sel_i,
   input  logic          m0_stb_i,
   input  logic          m0_cyc_i,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_data_i,
   output logic [DW-1:0] m1_data_o,
   input  logic          m1_we_i,
   input  logic [3:0]    m1_sel_i,
   input  logic          m1_stb_i,
   input  logic          m1_cyc_i,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [AW-1:0] s_addr_o,
   output logic [DW-1:0] s_data_o,
   input  logic [DW-1:0] s_data_i,
   output logic          s_we_o,
   output logic [3:0]    s_sel_o,
   output logic          s_stb_o,
   output logic          s_cyc_o,
   input  logic          s_ack_i,
   output logic [1:0]    grant_o
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_M0 = 2'd1,
      GRANT_M1 = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic          last_grant;   // 0 = m0 owned last, 1 = m1 owned last
   logic [CW-1:0] to_cnt;
   logic          own_m0, own_m1;
   logic          cur_cyc, cur_stb;
   logic          timeout_hit;

   always_comb begin
      own_m0      = (state == GRANT_M0);
      own_m1      = (state == GRANT_M1);
      cur_cyc     = (own_m0 & m0_cyc_i) | (own_m1 & m1_cyc_i);
      cur_stb     = (own_m0 & m0_stb_i) | (own_m1 & m1_stb_i);
      // An ack in the same cycle wins over the watchdog.
      timeout_hit = cur_stb & ~s_ack_i & (to_cnt == TO_LAST);
   end

   // State register, round-robin memory and watchdog counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         to_cnt     <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == GRANT_M0)
            last_grant <= 1'b0;
         else if (state == IDLE && state_nxt == GRANT_M1)
            last_grant <= 1'b1;
         if (state == IDLE || s_ack_i || timeout_hit)
            to_cnt <= '0;
         else if (cur_stb)
            to_cnt <= to_cnt + CW'(1);
      end
   end

   // Next-state logic: a new owner is only chosen from IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               state_nxt = last_grant ? GRANT_M0 : GRANT_M1;
            else if (m0_cyc_i)
               state_nxt = GRANT_M0;
            else if (m1_cyc_i)
               state_nxt = GRANT_M1;
         end
         GRANT_M0, GRANT_M1: begin
            if (!cur_cyc || timeout_hit)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output mux: everything not belonging to the owner is held at zero.
   always_comb begin
      grant_o   = {own_m1, own_m0};
      s_addr_o  = own_m0 ? m0_addr_i : (own_m1 ? m1_addr_i : '0);
      s_data_o  = own_m0 ? m0_data_i : (own_m1 ? m1_data_i : '0);
      s_sel_o   = own_m0 ? m0_sel_i  : (own_m1 ? m1_sel_i  : 4'b0000);
      s_we_o    = (own_m0 & m0_we_i) | (own_m1 & m1_we_i);
      s_cyc_o   = cur_cyc & ~timeout_hit;
      s_stb_o   = cur_stb & ~timeout_hit;
      m0_data_o = own_m0 ? s_data_i : '0;
      m1_data_o = own_m1 ? s_data_i : '0;
      m0_ack_o  = own_m0 & m0_stb_i & s_ack_i;
      m1_ack_o  = own_m1 & m1_stb_i & s_ack_i;
      m0_err_o  = own_m0 & timeout_hit;
      m1_err_o  = own_m1 & timeout_hit;
   end

endmodule
